// File: rtl/vend_credit_engine.sv
// Coin credit engine: synchronises coin inputs, accumulates credit, converts it into queued drops
// at PRICE, and releases them through a valid/ready handshake with refund and saturation support.
module vend_credit_engine #(
    parameter int NUM_COINS = 3,
    parameter int CREDIT_W = 5,
    parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VAL = {5'd5, 5'd3, 5'd1},
    parameter int PRICE = 4,
    parameter int MAX_PENDING = 3,
    parameter int PEND_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_COINS-1:0] coin_in,
    input  logic                 drop_ready,
    input  logic                 refund_req,
    output logic                 drop_valid,
    output logic [PEND_W-1:0]    drop_pending,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 refund_valid,
    output logic [CREDIT_W-1:0]  refund_amount,
    output logic [NUM_COINS-1:0] coin_seen,
    output logic                 overflow,
    output logic [1:0]           vend_state
);

    // Wide enough for current credit plus every coin arriving in the same cycle.
    localparam int SUM_W = CREDIT_W + $clog2(NUM_COINS) + 1;
    localparam logic [CREDIT_W-1:0] CREDIT_FULL = '1;
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'(CREDIT_FULL);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [SUM_W-1:0] PRICE_WIDE = SUM_W'(PRICE);
    localparam logic [PEND_W-1:0] MAX_PEND_C = PEND_W'(MAX_PENDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VEND  = 2'd1,
        STALL = 2'd2
    } vend_state_t;

    logic [NUM_COINS-1:0] sync1_reg, sync2_reg, hist_reg, coin_seen_reg;
    logic [NUM_COINS-1:0] coin_edge;
    logic [SUM_W-1:0]     coin_term [NUM_COINS];
    logic [SUM_W-1:0]     in_sum;

    logic [CREDIT_W-1:0]  credit_reg, credit_next;
    logic [PEND_W-1:0]    pending_reg, pending_next;
    logic                 drop_valid_reg;
    logic                 refund_valid_reg;
    logic [CREDIT_W-1:0]  refund_amount_reg;
    logic                 overflow_reg;
    vend_state_t          state_reg, state_next;

    logic [SUM_W-1:0]     total;
    logic [CREDIT_W-1:0]  total_sat;
    logic                 clamp;
    logic                 convert;
    logic                 transfer;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COINS; gi++) begin : g_coin
            assign coin_edge[gi] = sync2_reg[gi] & ~hist_reg[gi];
            assign coin_term[gi] = coin_edge[gi] ? SUM_W'(COIN_VAL[gi*CREDIT_W +: CREDIT_W]) : '0;
        end
    endgenerate

    always_comb begin
        in_sum = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            in_sum = in_sum + coin_term[i];
        end
    end

    // Refund beats conversion; at most one drop is created per cycle.
    always_comb begin
        transfer = drop_valid_reg & drop_ready;
        convert  = 1'b0;
        if (refund_req) begin
            total = SUM_W'(credit_reg) + in_sum;
        end else if ((credit_reg >= PRICE_C) && (pending_reg < MAX_PEND_C)) begin
            convert = 1'b1;
            total   = SUM_W'(credit_reg) - PRICE_WIDE + in_sum;
        end else begin
            total = SUM_W'(credit_reg) + in_sum;
        end
        clamp        = (total > CREDIT_MAX);
        total_sat    = clamp ? CREDIT_FULL : total[CREDIT_W-1:0];
        credit_next  = refund_req ? '0 : total_sat;
        pending_next = pending_reg + PEND_W'(convert) - PEND_W'(transfer);
        if (credit_next < PRICE_C) begin
            state_next = IDLE;
        end else if (pending_next == MAX_PEND_C) begin
            state_next = STALL;
        end else begin
            state_next = VEND;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg         <= '0;
            sync2_reg         <= '0;
            hist_reg          <= '0;
            coin_seen_reg     <= '0;
            credit_reg        <= '0;
            pending_reg       <= '0;
            drop_valid_reg    <= 1'b0;
            refund_valid_reg  <= 1'b0;
            refund_amount_reg <= '0;
            overflow_reg      <= 1'b0;
            state_reg         <= IDLE;
        end else begin
            sync1_reg        <= coin_in;
            sync2_reg        <= sync1_reg;
            hist_reg         <= sync2_reg;
            coin_seen_reg    <= coin_edge;
            credit_reg       <= credit_next;
            pending_reg      <= pending_next;
            drop_valid_reg   <= (pending_next != '0);
            refund_valid_reg <= refund_req;
            if (refund_req) begin
                refund_amount_reg <= total_sat;
            end
            overflow_reg     <= overflow_reg | clamp;
            state_reg        <= state_next;
        end
    end

    assign drop_valid    = drop_valid_reg;
    assign drop_pending  = pending_reg;
    assign credit        = credit_reg;
    assign refund_valid  = refund_valid_reg;
    assign refund_amount = refund_amount_reg;
    assign coin_seen     = coin_seen_reg;
    assign overflow      = overflow_reg;
    assign vend_state    = state_reg;

endmodule
